mon_mem_arbiter: RTL and testbench
==================================

Name: mon_mem_arbiter

Overview:
- Owns the single-port program/data memory and sequences the monitor commands that reach it: write stream, range dump, trash-clear.
- Shares the memory with the CPU; monitor operations have priority, and the CPU is granted only when the block is idle.
- Sits between the UART command controller (pulse inputs) and the memory, the CPU core, and the dump print formatter.

Parameters:
ADR_W, 8, memory address width; address counters wrap modulo 2^ADR_W.
DAT_W, 8, memory data width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
write_adr_dat  in  8  address/data byte from controller; valid in the same cycle as the set/enable pulses below
write_address_set  in  1  pulse: load write pointer from write_adr_dat
write_data_en  in  1  pulse: write write_adr_dat at write pointer, then increment pointer
read_start_set  in  1  pulse: load dump start address
read_end_set  in  1  pulse: load dump end address and start the dump
read_stop  in  1  pulse: abort dump
start_trush  in  1  pulse: start zero-fill of the whole memory
quit_cmd  in  1  pulse: abort any running dump or trash
dump_running  out  1  dump in progress
trush_running  out  1  trash in progress
cpu_req  in  1  CPU memory request, held until granted
cpu_we  in  1  CPU write enable
cpu_adr  in  ADR_W  CPU address
cpu_wdata  in  DAT_W  CPU write data
cpu_gnt  out  1  CPU access performed this cycle
cpu_rdata  out  DAT_W  read data; equals mem_rdata
mem_adr  out  ADR_W  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  DAT_W  memory write data
mem_rdata  in  DAT_W  synchronous read data, one-cycle latency
dump_data  out  DAT_W  dumped byte
dump_valid  out  1  dump_data valid; held until dump_ready
dump_ready  in  1  formatter accepts the byte

Behaviour:
- Reset: state IDLE. All pointers 0. All outputs 0, except cpu_rdata, which tracks mem_rdata.
- States:
  - IDLE
  - WRITE: one cycle
  - DRD: issue read
  - DLAT: capture read data
  - DWAIT: present byte to formatter
  - TRUSH: zero-fill
- IDLE, same-cycle priority: start_trush > read_end_set > pending write > cpu_req.
  - read_start_set and write_address_set only load registers; they never change state.
- Write:
  - write_data_en latches the data byte and sets a pending flag.
  - Next cycle (state WRITE): mem_we=1, mem_adr=wptr, mem_wdata=latched byte, wptr <= wptr+1 (0xFF wraps to 0x00).
  - Throughput is one byte per 2 cycles, which is sufficient for the UART rate.
  - write_data_en arriving during a dump or trash is dropped.
- Dump:
  - read_end_set loads rend and sets rptr=rstart, then moves to DRD.
  - DRD: mem_adr=rptr.
  - DLAT: dump_data <= mem_rdata, then go to DWAIT.
  - DWAIT: dump_valid=1 and dump_data stable until dump_ready.
    - On handshake with rptr==rend: IDLE.
    - On handshake otherwise: rptr++ (wrapping), then DRD.
  - The range is inclusive, with byte count (rend-rstart mod 256)+1. rend<rstart wraps through 0xFF. rend==rstart dumps exactly one byte.
- Trash:
  - start_trush sets tptr=0, then moves to TRUSH.
  - TRUSH, each cycle: mem_we=1, mem_adr=tptr, mem_wdata=0, tptr++.
  - After writing 0xFF, go to IDLE. Total 256 write cycles.
- Abort:
  - quit_cmd or read_stop in any DRD/DLAT/DWAIT state returns to IDLE next cycle and drops dump_valid. No further bytes are emitted, even if dump_ready is coincident.
  - quit_cmd in TRUSH stops next cycle; memory is left partially cleared.
- Running flags (combinational, so the controller does not see a zero in the cycle it enters its wait state):
  - dump_running = (state in DRD/DLAT/DWAIT) | read_end_set.
  - trush_running = (state==TRUSH) | start_trush.
- CPU access:
  - cpu_gnt = cpu_req & IDLE & no trash/dump start & no pending write (combinational).
  - When granted, mem_* is driven from cpu_* in the same cycle. Read data appears on cpu_rdata one cycle later.
  - When not granted, the CPU holds its request unchanged; no access is lost or duplicated.
- Memory bus when neither the monitor nor the CPU is active: mem_we=0, mem_adr holds its last value.
- Asynchronous reset mid-operation returns to IDLE immediately. No memory write is issued in the cycle reset is released.

Test Plan:
- Write stream: write_address_set with 0xFE, then data bytes 0x11, 0x22, 0x33 -> memory writes 0xFE=0x11, 0xFF=0x22, 0x00=0x33; wptr wraps; one mem_we per byte.
- Dump with backpressure: memory 0x10..0x12 = 0xA0, 0xA1, 0xA2; rstart=0x10, rend=0x12; dump_ready low for 5 cycles per byte -> exactly 3 handshakes, in order A0, A1, A2; dump_valid/dump_data stable while stalled; dump_running is 1 in the read_end_set cycle and 0 one cycle after the last handshake.
- Dump edge ranges: rstart=rend=0x40 -> 1 byte; rstart=0xFE, rend=0x01 -> 4 bytes from addresses FE, FF, 00, 01.
- Dump abort: read_stop while in DWAIT with dump_ready coincident -> no handshake counted, dump_valid=0 next cycle, state IDLE.
- Trash: start_trush -> 256 consecutive zero writes to addresses 0x00..0xFF; trush_running high in the start_trush cycle and falls after 0xFF; a second run with quit_cmd at tptr=0x80 -> last write at 0x80, addresses 0x81..0xFF untouched.
- CPU sharing: cpu_req held during a trash -> cpu_gnt=0 throughout; cpu_gnt=1 in the first IDLE cycle, and a read of 0x05 returns 0x00 on cpu_rdata the next cycle; cpu_req coincident with write_data_en -> the monitor write wins and the CPU is granted the following cycle.

Source files
------------

// File: rtl/mon_mem_arbiter.sv
// Monitor-side owner of the single-port program/data memory.
// Sequences write stream, range dump and trash-clear; CPU gets idle slots.
module mon_mem_arbiter #(
   parameter int ADR_W = 8,
   parameter int DAT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       write_adr_dat,
   input  logic             write_address_set,
   input  logic             write_data_en,
   input  logic             read_start_set,
   input  logic             read_end_set,
   input  logic             read_stop,
   input  logic             start_trush,
   input  logic             quit_cmd,
   output logic             dump_running,
   output logic             trush_running,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [ADR_W-1:0] cpu_adr,
   input  logic [DAT_W-1:0] cpu_wdata,
   output logic             cpu_gnt,
   output logic [DAT_W-1:0] cpu_rdata,
   output logic [ADR_W-1:0] mem_adr,
   output logic             mem_we,
   output logic [DAT_W-1:0] mem_wdata,
   input  logic [DAT_W-1:0] mem_rdata,
   output logic [DAT_W-1:0] dump_data,
   output logic             dump_valid,
   input  logic             dump_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_DRD,
      S_DLAT,
      S_DWAIT,
      S_TRUSH
   } state_t;

   state_t r_state;
   state_t w_nxt;

   logic [ADR_W-1:0] r_wptr;
   logic [DAT_W-1:0] r_wdat;
   logic             r_pend;
   logic [ADR_W-1:0] r_rstart;
   logic [ADR_W-1:0] r_rend;
   logic [ADR_W-1:0] r_rptr;
   logic [ADR_W-1:0] r_tptr;
   logic [ADR_W-1:0] r_adr;
   logic [DAT_W-1:0] r_dout;
   logic             r_live;

   logic             w_idle;
   logic             w_dump_st;
   logic             w_abort;
   logic             w_wr_acc;
   logic             w_pend;
   logic             w_trs_go;
   logic             w_dmp_go;
   logic             w_gnt;
   logic             w_hs;
   logic             w_we;
   logic [ADR_W-1:0] w_adr;
   logic [DAT_W-1:0] w_wdata;
   logic [ADR_W-1:0] w_byte_a;
   logic [DAT_W-1:0] w_byte_d;

   assign w_byte_a  = ADR_W'(write_adr_dat);
   assign w_byte_d  = DAT_W'(write_adr_dat);
   assign w_idle    = (r_state == S_IDLE);
   assign w_dump_st = (r_state == S_DRD) | (r_state == S_DLAT)
                    | (r_state == S_DWAIT);
   assign w_abort   = quit_cmd | read_stop;
   assign w_wr_acc  = write_data_en & ~w_dump_st & (r_state != S_TRUSH);
   assign w_pend    = r_pend | w_wr_acc;
   assign w_trs_go  = w_idle & start_trush;
   assign w_dmp_go  = w_idle & ~start_trush & read_end_set;
   // r_live keeps the CPU off the bus in the cycle reset is released
   assign w_gnt     = w_idle & r_live & cpu_req & ~start_trush
                    & ~read_end_set & ~w_pend;
   assign w_hs      = (r_state == S_DWAIT) & ~w_abort & dump_ready;

   always_comb begin
      w_nxt   = r_state;
      w_we    = 1'b0;
      w_adr   = r_adr;
      w_wdata = '0;
      unique case (r_state)
         S_IDLE: begin
            if (start_trush) begin
               w_nxt = S_TRUSH;
            end else if (read_end_set) begin
               w_nxt = S_DRD;
            end else if (w_pend) begin
               w_nxt = S_WRITE;
            end else if (w_gnt) begin
               w_we    = cpu_we;
               w_adr   = cpu_adr;
               w_wdata = cpu_wdata;
            end
         end
         S_WRITE: begin
            w_we    = 1'b1;
            w_adr   = r_wptr;
            w_wdata = r_wdat;
            w_nxt   = S_IDLE;
         end
         S_DRD: begin
            w_adr = r_rptr;
            w_nxt = w_abort ? S_IDLE : S_DLAT;
         end
         S_DLAT: begin
            w_nxt = w_abort ? S_IDLE : S_DWAIT;
         end
         S_DWAIT: begin
            if (w_abort) begin
               w_nxt = S_IDLE;
            end else if (dump_ready) begin
               w_nxt = (r_rptr == r_rend) ? S_IDLE : S_DRD;
            end
         end
         S_TRUSH: begin
            w_we  = 1'b1;
            w_adr = r_tptr;
            if (quit_cmd || (r_tptr == '1)) w_nxt = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_wptr   <= '0;
         r_wdat   <= '0;
         r_pend   <= 1'b0;
         r_rstart <= '0;
         r_rend   <= '0;
         r_rptr   <= '0;
         r_tptr   <= '0;
         r_adr    <= '0;
         r_dout   <= '0;
         r_live   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_adr   <= w_adr;
         r_live  <= 1'b1;
         if (write_address_set) r_wptr <= w_byte_a;
         else if (r_state == S_WRITE) r_wptr <= r_wptr + 1'b1;
         if (w_wr_acc) begin
            r_wdat <= w_byte_d;
            r_pend <= 1'b1;
         end else if (r_state == S_WRITE) begin
            r_pend <= 1'b0;
         end
         if (read_start_set) r_rstart <= w_byte_a;
         if (w_dmp_go) begin
            r_rend <= w_byte_a;
            r_rptr <= r_rstart;
         end else if (w_hs && (r_rptr != r_rend)) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_trs_go) r_tptr <= '0;
         else if (r_state == S_TRUSH) r_tptr <= r_tptr + 1'b1;
         if (r_state == S_DLAT) r_dout <= mem_rdata;
      end
   end

   assign mem_we        = w_we;
   assign mem_adr       = w_adr;
   assign mem_wdata     = w_wdata;
   assign cpu_gnt       = w_gnt;
   assign cpu_rdata     = mem_rdata;
   assign dump_data     = r_dout;
   assign dump_valid    = (r_state == S_DWAIT) & ~w_abort;
   assign dump_running  = w_dump_st | read_end_set;
   assign trush_running = (r_state == S_TRUSH) | start_trush;

endmodule

// File: tb/tb_mon_mem_arbiter.sv
// Directed bench for mon_mem_arbiter with a behavioural sync-read memory.
// Covers write stream, dumps, abort, trash and CPU sharing.
module tb_mon_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] write_adr_dat;
   logic       write_address_set;
   logic       write_data_en;
   logic       read_start_set;
   logic       read_end_set;
   logic       read_stop;
   logic       start_trush;
   logic       quit_cmd;
   logic       dump_running;
   logic       trush_running;
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_adr;
   logic [7:0] cpu_wdata;
   logic       cpu_gnt;
   logic [7:0] cpu_rdata;
   logic [7:0] mem_adr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [7:0] dump_data;
   logic       dump_valid;
   logic       dump_ready;

   logic       pk_en;
   logic       pk_fill;
   logic [7:0] pk_adr;
   logic [7:0] pk_dat;
   logic [7:0] mem [256];
   logic [7:0] wq_adr [$];
   logic [7:0] wq_dat [$];
   logic [7:0] hs [$];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mon_mem_arbiter #(.ADR_W(8), .DAT_W(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .write_adr_dat     (write_adr_dat),
      .write_address_set (write_address_set),
      .write_data_en     (write_data_en),
      .read_start_set    (read_start_set),
      .read_end_set      (read_end_set),
      .read_stop         (read_stop),
      .start_trush       (start_trush),
      .quit_cmd          (quit_cmd),
      .dump_running      (dump_running),
      .trush_running     (trush_running),
      .cpu_req           (cpu_req),
      .cpu_we            (cpu_we),
      .cpu_adr           (cpu_adr),
      .cpu_wdata         (cpu_wdata),
      .cpu_gnt           (cpu_gnt),
      .cpu_rdata         (cpu_rdata),
      .mem_adr           (mem_adr),
      .mem_we            (mem_we),
      .mem_wdata         (mem_wdata),
      .mem_rdata         (mem_rdata),
      .dump_data         (dump_data),
      .dump_valid        (dump_valid),
      .dump_ready        (dump_ready)
   );

   // memory model plus write and handshake loggers
   always @(posedge clk) begin
      if (pk_fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= pk_dat;
      end else if (mem_we) begin
         mem[mem_adr] <= mem_wdata;
      end else if (pk_en) begin
         mem[pk_adr] <= pk_dat;
      end
      mem_rdata <= mem[mem_adr];
      if (mem_we) begin
         wq_adr.push_back(mem_adr);
         wq_dat.push_back(mem_wdata);
      end
      if (dump_valid && dump_ready) hs.push_back(dump_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pk_en  = 1'b1;
      pk_adr = a;
      pk_dat = d;
      @(negedge clk);
      pk_en  = 1'b0;
   endtask

   task automatic dump_run(input logic [7:0] s, input logic [7:0] e,
                           input int n, input int stall);
      int k;
      logic [7:0] d0;
      @(negedge clk);
      write_adr_dat  = s;
      read_start_set = 1'b1;
      @(negedge clk);
      read_start_set = 1'b0;
      write_adr_dat  = e;
      read_end_set   = 1'b1;
      #1 chk("drun_at_set", dump_running, 1);
      @(negedge clk);
      read_end_set = 1'b0;
      for (int i = 0; i < n; i++) begin
         k = 0;
         #1;
         while (!dump_valid && k < 10) begin
            @(negedge clk);
            #1;
            k++;
         end
         chk("dvalid_wait", dump_valid, 1);
         d0 = dump_data;
         for (int j = 0; j < stall; j++) begin
            @(negedge clk);
            #1;
            chk("stall_valid", dump_valid, 1);
            chk("stall_data", dump_data, d0);
         end
         dump_ready = 1'b1;
         @(negedge clk);
         dump_ready = 1'b0;
      end
      #1;
      chk("drun_after", dump_running, 0);
      chk("dvalid_after", dump_valid, 0);
   endtask

   initial begin
      int hb;
      int wb;
      int n;
      int errs;
      logic [7:0] wbyte [3];
      logic [7:0] wexp [3];
      logic [7:0] dexp [4];

      rst_n = 1'b0;
      write_adr_dat = '0;
      write_address_set = 1'b0;
      write_data_en = 1'b0;
      read_start_set = 1'b0;
      read_end_set = 1'b0;
      read_stop = 1'b0;
      start_trush = 1'b0;
      quit_cmd = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_adr = '0;
      cpu_wdata = '0;
      dump_ready = 1'b0;
      pk_en = 1'b0;
      pk_adr = '0;
      pk_fill = 1'b1;
      pk_dat = 8'h5A;
      repeat (3) @(negedge clk);
      pk_fill = 1'b0;
      #1;
      chk("rst_drun", dump_running, 0);
      chk("rst_trun", trush_running, 0);
      chk("rst_gnt", cpu_gnt, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_adr", mem_adr, 0);
      chk("rst_dvalid", dump_valid, 0);
      chk("rst_ddata", dump_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_we", mem_we, 0);

      // write stream wrapping through 0xFF
      wbyte[0] = 8'h11; wbyte[1] = 8'h22; wbyte[2] = 8'h33;
      wexp[0] = 8'hFE;  wexp[1] = 8'hFF;  wexp[2] = 8'h00;
      wb = wq_adr.size();
      @(negedge clk);
      write_adr_dat = 8'hFE;
      write_address_set = 1'b1;
      @(negedge clk);
      write_address_set = 1'b0;
      for (int i = 0; i < 3; i++) begin
         write_adr_dat = wbyte[i];
         write_data_en = 1'b1;
         @(negedge clk);
         write_data_en = 1'b0;
         #1;
         chk("wr_we", mem_we, 1);
         chk("wr_adr", mem_adr, wexp[i]);
         chk("wr_dat", mem_wdata, wbyte[i]);
         @(negedge clk);
         #1 chk("wr_idle_we", mem_we, 0);
      end
      chk("wr_count", wq_adr.size() - wb, 3);
      chk("mem_FE", mem[8'hFE], 8'h11);
      chk("mem_FF", mem[8'hFF], 8'h22);
      chk("mem_00", mem[8'h00], 8'h33);

      // CPU request coincident with a monitor write
      @(negedge clk);
      write_adr_dat = 8'h44;
      write_data_en = 1'b1;
      cpu_req = 1'b1;
      cpu_adr = 8'h05;
      cpu_we = 1'b0;
      #1 chk("cw_gnt0", cpu_gnt, 0);
      @(negedge clk);
      write_data_en = 1'b0;
      #1;
      chk("cw_gnt1", cpu_gnt, 0);
      chk("cw_we", mem_we, 1);
      chk("cw_adr", mem_adr, 8'h01);
      @(negedge clk);
      #1;
      chk("cw_gnt2", cpu_gnt, 1);
      chk("cw_cadr", mem_adr, 8'h05);
      chk("cw_cwe", mem_we, 0);
      @(negedge clk);
      cpu_req = 1'b0;
      chk("cw_rdata", cpu_rdata, 8'h5A);

      // dumps
      poke(8'h10, 8'hA0);
      poke(8'h11, 8'hA1);
      poke(8'h12, 8'hA2);
      poke(8'h40, 8'hC4);
      hb = hs.size();
      dump_run(8'h10, 8'h12, 3, 5);
      chk("d3_count", hs.size() - hb, 3);
      dexp[0] = 8'hA0; dexp[1] = 8'hA1; dexp[2] = 8'hA2;
      for (int i = 0; i < 3; i++)
         if (hs.size() > hb + i) chk("d3_byte", hs[hb+i], dexp[i]);

      hb = hs.size();
      dump_run(8'h40, 8'h40, 1, 0);
      chk("d1_count", hs.size() - hb, 1);
      if (hs.size() > hb) chk("d1_byte", hs[hb], 8'hC4);

      hb = hs.size();
      dump_run(8'hFE, 8'h01, 4, 1);
      chk("dw_count", hs.size() - hb, 4);
      dexp[0] = 8'h11; dexp[1] = 8'h22; dexp[2] = 8'h33; dexp[3] = 8'h44;
      for (int i = 0; i < 4; i++)
         if (hs.size() > hb + i) chk("dw_byte", hs[hb+i], dexp[i]);

      // abort in DWAIT with coincident ready
      hb = hs.size();
      @(negedge clk);
      write_adr_dat = 8'h20;
      read_start_set = 1'b1;
      @(negedge clk);
      read_start_set = 1'b0;
      write_adr_dat = 8'h2F;
      read_end_set = 1'b1;
      @(negedge clk);
      read_end_set = 1'b0;
      n = 0;
      #1;
      while (!dump_valid && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("ab_valid", dump_valid, 1);
      read_stop = 1'b1;
      dump_ready = 1'b1;
      #1 chk("ab_valid_stop", dump_valid, 0);
      @(negedge clk);
      read_stop = 1'b0;
      dump_ready = 1'b0;
      cpu_req = 1'b1;
      #1;
      chk("ab_valid_next", dump_valid, 0);
      chk("ab_drun", dump_running, 0);
      chk("ab_idle_gnt", cpu_gnt, 1);
      chk("ab_no_hs", hs.size() - hb, 0);
      @(negedge clk);
      cpu_req = 1'b0;

      // full trash with CPU held off
      wb = wq_adr.size();
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_adr = 8'h05;
      cpu_we = 1'b0;
      start_trush = 1'b1;
      #1;
      chk("tr_run_start", trush_running, 1);
      chk("tr_gnt_start", cpu_gnt, 0);
      @(negedge clk);
      start_trush = 1'b0;
      n = 0;
      errs = 0;
      #1;
      while (trush_running && n < 300) begin
         if (cpu_gnt) errs++;
         @(negedge clk);
         #1;
         n++;
      end
      chk("tr_cycles", n, 256);
      chk("tr_gnt_during", errs, 0);
      chk("tr_gnt_idle", cpu_gnt, 1);
      chk("tr_wcount", wq_adr.size() - wb, 256);
      errs = 0;
      for (int i = 0; i < 256; i++) begin
         if (wq_adr.size() > wb + i) begin
            if (wq_adr[wb+i] != 8'(i) || wq_dat[wb+i] != 8'h00) errs++;
         end
      end
      chk("tr_wseq", errs, 0);
      @(negedge clk);
      cpu_req = 1'b0;
      chk("tr_cpu_rd", cpu_rdata, 8'h00);

      // trash aborted at 0x80
      @(negedge clk);
      pk_fill = 1'b1;
      pk_dat = 8'h5A;
      @(negedge clk);
      pk_fill = 1'b0;
      wb = wq_adr.size();
      start_trush = 1'b1;
      @(negedge clk);
      start_trush = 1'b0;
      n = 0;
      #1;
      while (!(mem_we && mem_adr == 8'h80) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("tq_reach80", mem_adr, 8'h80);
      quit_cmd = 1'b1;
      @(negedge clk);
      quit_cmd = 1'b0;
      #1;
      chk("tq_trun", trush_running, 0);
      chk("tq_we", mem_we, 0);
      chk("tq_wcount", wq_adr.size() - wb, 129);
      if (wq_adr.size() > wb)
         chk("tq_last", wq_adr[wq_adr.size()-1], 8'h80);
      chk("tq_mem80", mem[8'h80], 8'h00);
      chk("tq_mem81", mem[8'h81], 8'h5A);
      chk("tq_memFF", mem[8'hFF], 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
